// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types for the ROB commit controller: FSM states and the head retire classification.
package rob_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StStReq,
    StSquash,
    StHalted
  } commit_state_e;

  typedef enum logic [2:0] {
    RkNone,
    RkNormal,
    RkStore,
    RkMispredict,
    RkHalt
  } retire_kind_e;

  // Resolve what the head wants to do; halt > mispredict > store > normal.
  function automatic retire_kind_e head_kind(input logic ready, input logic is_halt,
                                             input logic is_mispredict, input logic is_store);
    if (!ready) return RkNone;
    if (is_halt) return RkHalt;
    if (is_mispredict) return RkMispredict;
    if (is_store) return RkStore;
    return RkNormal;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_timeout.sv
// Saturating wait counter for the store-commit handshake; tc_o pulses on the increment
// that brings the count to Limit.
module rob_commit_ctrl_timeout #(
  parameter int unsigned Limit = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(Limit);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc_o = en_i & ~clr_i & (cnt_q == LastCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB head retirement sequencer: RF writeback, store commit handshake, mispredict squash
// pulse and halt.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned TagW      = 3,
  parameter int unsigned CntW      = 32,
  parameter int unsigned StTimeout = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            head_valid_i,
  input  logic            head_complete_i,
  input  logic [TagW-1:0] head_tag_i,
  input  logic            head_is_store_i,
  input  logic            head_mispredict_i,
  input  logic            head_halt_i,
  input  logic            head_has_dest_i,
  input  logic [4:0]      head_dest_reg_i,
  input  logic [31:0]     head_value_i,
  input  logic [31:0]     head_target_pc_i,
  input  logic            retire_stall_i,
  input  logic            rob_empty_i,
  input  logic            st_commit_ack_i,
  output logic            retire_en_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [31:0]     rf_wdata_o,
  output logic            st_commit_req_o,
  output logic [TagW-1:0] st_commit_tag_o,
  output logic            squash_valid_o,
  output logic [TagW-1:0] squash_tag_o,
  output logic [31:0]     squash_pc_o,
  output logic            halted_o,
  output logic [CntW-1:0] retired_count_o,
  output logic            st_timeout_err_o
);

  commit_state_e   state_q, state_d;
  retire_kind_e    kind;
  logic            ready;
  logic            head_writes_rf;
  logic [TagW-1:0] st_tag_q, st_tag_d;
  logic            sq_valid_q, sq_valid_d;
  logic [TagW-1:0] sq_tag_q, sq_tag_d;
  logic [31:0]     sq_pc_q, sq_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic            tmo_clr, tmo_en, tmo_tc;

  assign ready          = head_valid_i & head_complete_i & ~retire_stall_i;
  assign kind           = head_kind(ready, head_halt_i, head_mispredict_i, head_is_store_i);
  assign head_writes_rf = head_has_dest_i & (head_dest_reg_i != 5'd0);

  always_comb begin
    state_d     = state_q;
    retire_en_o = 1'b0;
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    st_tag_d    = st_tag_q;
    sq_valid_d  = 1'b0;
    sq_tag_d    = sq_tag_q;
    sq_pc_d     = sq_pc_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;

    unique case (state_q)
      StRun: begin
        unique case (kind)
          RkNormal, RkMispredict: begin
            retire_en_o = 1'b1;
            if (head_writes_rf) begin
              rf_we_o    = 1'b1;
              rf_waddr_o = head_dest_reg_i;
              rf_wdata_o = head_value_i;
            end
            if (kind == RkMispredict) begin
              sq_valid_d = 1'b1;
              sq_tag_d   = head_tag_i;
              sq_pc_d    = head_target_pc_i;
              state_d    = StSquash;
            end
          end
          RkHalt: begin
            retire_en_o = 1'b1;
            state_d     = StHalted;
          end
          RkStore: begin
            st_tag_d = head_tag_i;
            tmo_clr  = 1'b1;
            state_d  = StStReq;
          end
          default: ;
        endcase
      end
      StStReq: begin
        // The ack retire is deliberately not gated by retire_stall_i.
        if (st_commit_ack_i) begin
          retire_en_o = 1'b1;
          state_d     = StRun;
        end else begin
          tmo_en = 1'b1;
        end
      end
      StSquash: begin
        // Skip the exit check during the squash pulse cycle.
        if (!sq_valid_q && rob_empty_i) begin
          state_d = StRun;
        end
      end
      StHalted: ;
      default: state_d = StRun;
    endcase
  end

  assign count_d = count_q + CntW'(retire_en_o);
  assign err_d   = err_q | tmo_tc;

  rob_commit_ctrl_timeout #(
    .Limit(StTimeout)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      st_tag_q   <= '0;
      sq_valid_q <= 1'b0;
      sq_tag_q   <= '0;
      sq_pc_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_tag_q   <= st_tag_d;
      sq_valid_q <= sq_valid_d;
      sq_tag_q   <= sq_tag_d;
      sq_pc_q    <= sq_pc_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign st_commit_req_o  = (state_q == StStReq);
  assign st_commit_tag_o  = st_tag_q;
  assign squash_valid_o   = sq_valid_q;
  assign squash_tag_o     = sq_tag_q;
  assign squash_pc_o      = sq_pc_q;
  assign halted_o         = (state_q == StHalted);
  assign retired_count_o  = count_q;
  assign st_timeout_err_o = err_q;

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Retirement sequencer at the ROB head. It decides each cycle whether the head entry may retire, then performs the retire.
- Retire actions: register-file writeback, store commit handshake with the LSQ/D-cache, one-shot squash on a mispredicted branch, halt.
- Drives the ROB pop strobe and the SQUASH_PACKET consumed by the ROB, RS and map table.

Parameters:
- TAG_W, 3, ROB tag width (matches ROB_TAG; tag 0 is reserved as null).
- CNT_W, 32, width of retired-instruction counter.
- ST_TIMEOUT, 64, cycles in ST_REQ without ack before the error flag sets.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- head_valid  in  1  ROB head holds a dispatched entry
- head_complete  in  1  head result broadcast on CDB
- head_tag  in  TAG_W  ROB tag of head
- head_is_store  in  1  head is a store
- head_mispredict  in  1  head is a resolved mispredicted branch
- head_halt  in  1  head is WFI/halt
- head_has_dest  in  1  head writes an architectural register
- head_dest_reg  in  5  destination register index
- head_value  in  32  head result value
- head_target_pc  in  32  correct PC for the mispredicted branch
- retire_stall  in  1  backpressure from register file / map table
- rob_empty  in  1  ROB holds no valid entries
- st_commit_ack  in  1  LSQ accepted the store
- retire_en  out  1  pop ROB head this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- st_commit_req  out  1  request store commit
- st_commit_tag  out  TAG_W  tag of store being committed
- squash_valid  out  1  one-cycle squash pulse
- squash_tag  out  TAG_W  tag of the mispredicted branch
- squash_pc  out  32  redirect PC
- halted  out  1  processor halted
- retired_count  out  CNT_W  instructions retired since reset
- st_timeout_err  out  1  sticky store-ack timeout flag

Behaviour:
- FSM states: RUN, ST_REQ, SQUASH, HALTED. Reset state is RUN.
- Reset values: all registered outputs 0, counters 0, state RUN.
- Reset is asynchronous. Asserting it mid-store or mid-squash aborts to RUN with no retire and no pulse.
- ready = head_valid & head_complete & ~retire_stall.
- RUN, ready, normal entry (no store/mispredict/halt):
  - retire_en=1 combinationally in the same cycle.
  - rf_we = head_has_dest & (head_dest_reg != 0); rf_waddr = head_dest_reg; rf_wdata = head_value.
  - Throughput is 1 retire per cycle.
- RUN, ready, head_is_store:
  - No retire this cycle; next state ST_REQ.
  - st_commit_tag is latched to head_tag.
- ST_REQ:
  - st_commit_req=1 (registered), held until ack.
  - On st_commit_ack: retire_en=1 the same cycle, rf_we=0, next state RUN.
  - Ack arriving when not in ST_REQ is ignored.
  - A wait counter increments each ST_REQ cycle without ack. When it reaches ST_TIMEOUT, st_timeout_err=1 (sticky until reset) and the FSM stays in ST_REQ.
  - The counter clears on entry to ST_REQ.
- RUN, ready, head_mispredict:
  - retire_en=1 and the link register write proceeds this cycle.
  - squash_tag and squash_pc are registered.
  - Next cycle: squash_valid=1 for exactly one cycle; state SQUASH.
- SQUASH:
  - retire_en=0 and rf_we=0 regardless of head inputs.
  - Exit to RUN on the first cycle rob_empty=1; the exit check is not made in the squash_valid cycle itself.
- RUN, ready, head_halt:
  - retire_en=1 with no RF write; next state HALTED.
  - halted=1 from the next cycle, held until reset.
- HALTED: all strobes 0; head inputs ignored.
- Priority when several head flags are set: halt > mispredict > store > normal.
- retire_stall=1 blocks retire entry from RUN. It does not gate the ST_REQ ack retire.
- retired_count increments on every retire_en cycle and wraps modulo 2^CNT_W.
- head_valid=0 or head_complete=0 in RUN: no action; outputs 0.
- Combinational outputs (retire_en, rf_*) are 0 whenever the state is not RUN/ST_REQ.

Decomposition:
- Shared package (sys_defs.svh): COMMIT_STATE enum {RUN, ST_REQ, SQUASH, HALTED}; ROB_TAG typedef; reuse of SQUASH_PACKET with squash_valid/rob_tag plus new pc field.
- Natural sub-module: commit_timeout_counter (load/clear, enable, terminal-count flag). The FSM stays in the top module.

Test Plan:
- Reset then head_valid=1, complete=1, dest=5, value=0xDEAD_BEEF -> same cycle retire_en=1, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retired_count=1.
- Head store tag=3 complete -> st_commit_req=1 next cycle, st_commit_tag=3. Ack after 4 cycles -> retire_en=1 in the ack cycle, then RUN.
- Store with no ack for 64 cycles -> st_timeout_err=1 on cycle 64 and stays 1; a later ack still retires.
- Mispredict at tag=6, target=0x100 -> retire_en=1. Next cycle squash_valid=1, squash_tag=6, squash_pc=0x100 for one cycle. No retire until rob_empty=1, then RUN.
- Head with dest_reg=0 and has_dest=1 -> retire_en=1, rf_we=0. retire_stall=1 with a ready head -> retire_en=0.
- Halt retires -> halted=1 next cycle and stays. Drop reset to 0 mid-ST_REQ -> all outputs 0 immediately, state RUN.
